apb_rr_arbiter: RTL and testbench

Two-requester APB bus controller that shares the APB segment, with slave 1 at PADDR[8]=0 and slave 2 at PADDR[8]=1, between two independent clients. It arbitrates round-robin and sequences the SETUP/ACCESS phases. It decodes PADDR[8] into PSEL1/PSEL2 and muxes the slave responses back. A wait-state timeout guarantees that every accepted request completes.

---
 rtl/apb_rr_arbiter_if.sv | 48 ++++
 rtl/apb_rr_arbiter.sv | 107 ++++++++++
 tb/tb_apb_rr_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_rr_arbiter_if.sv
// Bundle of client-side request/response signals and the shared APB segment
// for the two-client round-robin APB controller.
interface apb_rr_arbiter_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 8
);
  // Client side
  logic              req0;
  logic              req1;
  logic              wr0;
  logic              wr1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata;
  logic              err;

  // APB side
  logic              PSEL1;
  logic              PSEL2;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA1;
  logic [DATA_W-1:0] PRDATA2;
  logic              PREADY1;
  logic              PREADY2;

  modport master (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, done0, done1, rdata, err,
    output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA1, PRDATA2, PREADY1, PREADY2
  );

  modport slave (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, done0, done1, rdata, err,
    input  PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA1, PRDATA2, PREADY1, PREADY2
  );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Two-client APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// address-MSB slave decode and a wait-state timeout that forces completion.
module apb_rr_arbiter #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              PCLK,
  input  logic              PRST,
  apb_rr_arbiter_if.master  bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSetup  = 2'd1;
  localparam logic [1:0] StAccess = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_q;
  logic              owner_q;
  logic [CntW-1:0]   wait_q;
  logic [ADDR_W-1:0] paddr_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] pwdata_q;

  logic              sel_hi;
  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;
  logic              complete;
  logic              window;
  logic              gnt0, gnt1;
  logic              accept;
  logic              acc_id;
  logic              acc_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  assign sel_hi    = paddr_q[ADDR_W-1];
  assign sel_ready = sel_hi ? bus.PREADY2 : bus.PREADY1;
  assign sel_rdata = sel_hi ? bus.PRDATA2 : bus.PRDATA1;

  assign complete = (state_q == StAccess) && (sel_ready || (wait_q == CntW'(TIMEOUT)));
  assign window   = (state_q == StIdle) || complete;

  // On a tie the requester that was not served last wins.
  assign gnt0 = window && bus.req0 && (!bus.req1 || last_q);
  assign gnt1 = window && bus.req1 && (!bus.req0 || !last_q);

  assign accept    = gnt0 || gnt1;
  assign acc_id    = gnt1;
  assign acc_wr    = acc_id ? bus.wr1    : bus.wr0;
  assign acc_addr  = acc_id ? bus.addr1  : bus.addr0;
  assign acc_wdata = acc_id ? bus.wdata1 : bus.wdata0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (accept) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (complete) state_d = accept ? StSetup : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRST) begin
    if (!PRST) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      wait_q   <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q  <= acc_id;
        last_q   <= acc_id;
        paddr_q  <= acc_addr;
        pwrite_q <= acc_wr;
        if (acc_wr) pwdata_q <= acc_wdata;
      end
      // Cleared while in SETUP so every ACCESS phase starts counting from zero.
      if (state_q == StSetup) begin
        wait_q <= '0;
      end else if ((state_q == StAccess) && !sel_ready) begin
        wait_q <= wait_q + CntW'(1);
      end
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.done0   = complete && !owner_q;
  assign bus.done1   = complete && owner_q;
  assign bus.err     = complete && !sel_ready;
  assign bus.rdata   = (complete && sel_ready && !pwrite_q) ? sel_rdata : '0;

  assign bus.PSEL1   = (state_q != StIdle) && !sel_hi;
  assign bus.PSEL2   = (state_q != StIdle) && sel_hi;
  assign bus.PENABLE = (state_q == StAccess);
  assign bus.PWRITE  = pwrite_q;
  assign bus.PADDR   = paddr_q;
  assign bus.PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed scenarios followed by a randomized run checked against a
// transaction-level model of the two-client round-robin APB controller.
module tb_apb_rr_arbiter;

  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned TIMEOUT = 15;

  logic PCLK = 1'b0;
  logic PRST = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  apb_rr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .PCLK (PCLK),
    .PRST (PRST),
    .bus  (bif)
  );

  // Two simple slaves; contents reload to a known pattern whenever reset is low.
  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];

  always @(posedge PCLK or negedge PRST) begin
    if (!PRST) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= 8'(i) ^ 8'hC3;
        mem2[i] <= 8'(i) ^ 8'h08;
      end
    end else begin
      if (bif.PSEL1 && bif.PENABLE && bif.PREADY1 && bif.PWRITE) mem1[bif.PADDR[7:0]] <= bif.PWDATA;
      if (bif.PSEL2 && bif.PENABLE && bif.PREADY2 && bif.PWRITE) mem2[bif.PADDR[7:0]] <= bif.PWDATA;
    end
  end

  assign bif.PRDATA1 = mem1[bif.PADDR[7:0]];
  assign bif.PRDATA2 = mem2[bif.PADDR[7:0]];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Transaction-level reference model state
  typedef struct {
    logic       wr;
    logic [8:0] addr;
    logic [7:0] wdata;
  } xfer_t;

  xfer_t      pend [2];
  bit         pending [2];
  xfer_t      cur;
  int         age;     // 0: no transfer, 1: SETUP, n>=2: ACCESS cycle n-1
  int         waits;   // PREADY-low ACCESS cycles seen so far in this transfer
  int         m_last;
  int         m_owner;
  logic [7:0] ref_mem [512];

  initial begin
    bit         sel_rdy, completing, window, eg0, eg1;
    logic [7:0] exp_rdata;
    int         x;

    bif.req0 = 1'b0; bif.wr0 = 1'b0; bif.addr0 = '0; bif.wdata0 = '0;
    bif.req1 = 1'b0; bif.wr1 = 1'b0; bif.addr1 = '0; bif.wdata1 = '0;
    bif.PREADY1 = 1'b1;
    bif.PREADY2 = 1'b1;

    // Reset state
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_psel1",   bif.PSEL1,   0);
    chk("rst_psel2",   bif.PSEL2,   0);
    chk("rst_penable", bif.PENABLE, 0);
    chk("rst_pwrite",  bif.PWRITE,  0);
    chk("rst_paddr",   bif.PADDR,   0);
    chk("rst_pwdata",  bif.PWDATA,  0);
    chk("rst_done",    {bif.done0, bif.done1, bif.err}, 0);
    chk("rst_rdata",   bif.rdata,   0);
    tick();
    PRST = 1'b1;

    // Single zero-wait write to slave 1
    bif.req0 = 1'b1; bif.wr0 = 1'b1; bif.addr0 = 9'h012; bif.wdata0 = 8'hA5;
    @(negedge PCLK);
    chk("wr_gnt0", bif.gnt0, 1);
    chk("wr_gnt1", bif.gnt1, 0);
    tick();
    bif.req0 = 1'b0;
    @(negedge PCLK);
    chk("wr_setup_psel1",   bif.PSEL1,   1);
    chk("wr_setup_penable", bif.PENABLE, 0);
    chk("wr_setup_paddr",   bif.PADDR,   9'h012);
    chk("wr_setup_pwdata",  bif.PWDATA,  8'hA5);
    tick();
    @(negedge PCLK);
    chk("wr_acc_penable", bif.PENABLE, 1);
    chk("wr_acc_done0",   bif.done0,   1);
    chk("wr_acc_done1",   bif.done1,   0);
    chk("wr_acc_err",     bif.err,     0);
    tick();
    chk("wr_mem1", mem1[8'h12], 8'hA5);
    @(negedge PCLK);
    chk("wr_idle_psel1", bif.PSEL1, 0);
    chk("wr_idle_paddr", bif.PADDR, 9'h012);

    // Read from slave 2 with three wait states
    tick();
    bif.req1 = 1'b1; bif.wr1 = 1'b0; bif.addr1 = 9'h134; bif.PREADY2 = 1'b0;
    @(negedge PCLK);
    chk("rd_gnt1", bif.gnt1, 1);
    tick();
    bif.req1 = 1'b0;
    @(negedge PCLK);
    chk("rd_psel2",   bif.PSEL2,   1);
    chk("rd_psel1",   bif.PSEL1,   0);
    chk("rd_penable", bif.PENABLE, 0);
    tick();
    for (int i = 1; i <= 3; i++) begin
      @(negedge PCLK);
      chk("rd_wait_penable", bif.PENABLE, 1);
      chk("rd_wait_done1",   bif.done1,   0);
      tick();
    end
    bif.PREADY2 = 1'b1;
    @(negedge PCLK);
    chk("rd_done1", bif.done1, 1);
    chk("rd_rdata", bif.rdata, 8'h3C);
    chk("rd_err",   bif.err,   0);
    tick();

    // Contention: grants alternate 0,1,0,1 with no idle bubble
    bif.req0 = 1'b1; bif.wr0 = 1'b1; bif.addr0 = 9'h020; bif.wdata0 = 8'h11;
    bif.req1 = 1'b1; bif.wr1 = 1'b1; bif.addr1 = 9'h021; bif.wdata1 = 8'h22;
    for (int k = 0; k < 4; k++) begin
      @(negedge PCLK);
      chk("ct_gnt0",    bif.gnt0,    (k % 2) == 0);
      chk("ct_gnt1",    bif.gnt1,    (k % 2) == 1);
      chk("ct_penable", bif.PENABLE, k > 0);
      chk("ct_done0",   bif.done0,   (k % 2) == 1);
      chk("ct_done1",   bif.done1,   (k > 0) && ((k % 2) == 0));
      tick();
      if (k == 2) bif.req0 = 1'b0;
      if (k == 3) bif.req1 = 1'b0;
      @(negedge PCLK);
      chk("ct_setup_psel1",   bif.PSEL1,   1);
      chk("ct_setup_penable", bif.PENABLE, 0);
      tick();
    end
    @(negedge PCLK);
    chk("ct_last_done1", bif.done1, 1);
    chk("ct_last_gnt",   {bif.gnt0, bif.gnt1}, 0);
    tick();
    chk("ct_mem20", mem1[8'h20], 8'h11);
    chk("ct_mem21", mem1[8'h21], 8'h22);

    // Request arriving in the owner-0 completion cycle
    bif.req0 = 1'b1; bif.wr0 = 1'b0; bif.addr0 = 9'h040;
    @(negedge PCLK);
    chk("sc_gnt0", bif.gnt0, 1);
    tick();
    bif.req0 = 1'b0;
    tick();
    bif.req1 = 1'b1; bif.wr1 = 1'b1; bif.addr1 = 9'h150; bif.wdata1 = 8'h77;
    @(negedge PCLK);
    chk("sc_done0", bif.done0, 1);
    chk("sc_rdata", bif.rdata, 8'h40 ^ 8'hC3);
    chk("sc_gnt1",  bif.gnt1,  1);
    tick();
    bif.req1 = 1'b0;
    @(negedge PCLK);
    chk("sc_psel2",   bif.PSEL2,   1);
    chk("sc_penable", bif.PENABLE, 0);
    chk("sc_paddr",   bif.PADDR,   9'h150);
    tick();
    @(negedge PCLK);
    chk("sc_done1", bif.done1, 1);
    tick();
    chk("sc_mem2", mem2[8'h50], 8'h77);

    // Timeout with slave 1 stuck
    bif.PREADY1 = 1'b0;
    bif.req0 = 1'b1; bif.wr0 = 1'b0; bif.addr0 = 9'h005;
    @(negedge PCLK);
    chk("to_gnt0", bif.gnt0, 1);
    tick();
    bif.req0 = 1'b0;
    tick();
    for (int i = 1; i <= 15; i++) begin
      @(negedge PCLK);
      chk("to_wait_done0", bif.done0, 0);
      tick();
    end
    @(negedge PCLK);
    chk("to_done0", bif.done0, 1);
    chk("to_err",   bif.err,   1);
    chk("to_rdata", bif.rdata, 0);
    tick();
    @(negedge PCLK);
    chk("to_idle_penable", bif.PENABLE, 0);
    chk("to_idle_psel1",   bif.PSEL1,   0);
    tick();

    // Reset in the middle of ACCESS
    bif.req0 = 1'b1; bif.wr0 = 1'b1; bif.addr0 = 9'h0F0; bif.wdata0 = 8'h99;
    @(negedge PCLK);
    chk("ra_gnt0", bif.gnt0, 1);
    tick();
    bif.req0 = 1'b0;
    tick();
    @(negedge PCLK);
    chk("ra_penable", bif.PENABLE, 1);
    #2 PRST = 1'b0;
    #1;
    chk("ra_psel1",   bif.PSEL1,   0);
    chk("ra_penable0", bif.PENABLE, 0);
    chk("ra_paddr",   bif.PADDR,   0);
    chk("ra_pwrite",  bif.PWRITE,  0);
    chk("ra_pwdata",  bif.PWDATA,  0);
    chk("ra_done0",   bif.done0,   0);
    bif.req0 = 1'b1;
    bif.PREADY1 = 1'b1;
    #1;
    chk("ra_gnt_in_reset", bif.gnt0, 1);
    tick();
    tick();
    PRST = 1'b1;
    @(negedge PCLK);
    chk("ra_regnt0", bif.gnt0, 1);
    tick();
    bif.req0 = 1'b0;
    tick();
    @(negedge PCLK);
    chk("ra_redone0", bif.done0, 1);
    tick();

    // Randomized run against the reference model, from a fresh reset
    PRST = 1'b0;
    tick();
    PRST = 1'b1;
    for (int a = 0; a < 256; a++) begin
      ref_mem[a]       = 8'(a) ^ 8'hC3;
      ref_mem[256 + a] = 8'(a) ^ 8'h08;
    end
    pending[0] = 1'b0;
    pending[1] = 1'b0;
    age     = 0;
    waits   = 0;
    m_last  = 1;
    m_owner = 0;
    cur.wr = 1'b0; cur.addr = '0; cur.wdata = '0;

    for (int c = 0; c < 600; c++) begin
      @(negedge PCLK);
      sel_rdy    = cur.addr[8] ? bif.PREADY2 : bif.PREADY1;
      completing = (age >= 2) && (sel_rdy || (waits == int'(TIMEOUT)));
      window     = (age == 0) || completing;
      eg0 = window && pending[0] && (!pending[1] || (m_last == 1));
      eg1 = window && pending[1] && (!pending[0] || (m_last == 0));
      chk("rnd_gnt0",    bif.gnt0,    eg0);
      chk("rnd_gnt1",    bif.gnt1,    eg1);
      chk("rnd_penable", bif.PENABLE, age >= 2);
      chk("rnd_psel1",   bif.PSEL1,   (age >= 1) && !cur.addr[8]);
      chk("rnd_psel2",   bif.PSEL2,   (age >= 1) && cur.addr[8]);
      chk("rnd_done0",   bif.done0,   completing && (m_owner == 0));
      chk("rnd_done1",   bif.done1,   completing && (m_owner == 1));
      if (age >= 1) chk("rnd_paddr", bif.PADDR, cur.addr);
      if (completing) begin
        exp_rdata = (sel_rdy && !cur.wr) ? ref_mem[cur.addr] : 8'h00;
        chk("rnd_err",   bif.err,   !sel_rdy);
        chk("rnd_rdata", bif.rdata, exp_rdata);
      end

      @(posedge PCLK);
      if (completing && sel_rdy && cur.wr) ref_mem[cur.addr] = cur.wdata;
      if (eg0 || eg1) begin
        x = eg0 ? 0 : 1;
        cur        = pend[x];
        pending[x] = 1'b0;
        m_owner    = x;
        m_last     = x;
        age        = 1;
        waits      = 0;
      end else if (completing) begin
        age = 0;
      end else if (age >= 1) begin
        if (age >= 2 && !sel_rdy) waits++;
        age++;
      end

      #1;
      for (int y = 0; y < 2; y++) begin
        if (!pending[y] && ($urandom_range(0, 2) == 0)) begin
          pending[y]    = 1'b1;
          pend[y].wr    = 1'($urandom_range(0, 1));
          pend[y].addr  = 9'($urandom_range(0, 511));
          pend[y].wdata = 8'($urandom);
        end
      end
      bif.req0 = pending[0]; bif.wr0 = pend[0].wr; bif.addr0 = pend[0].addr;
      bif.wdata0 = pend[0].wdata;
      bif.req1 = pending[1]; bif.wr1 = pend[1].wr; bif.addr1 = pend[1].addr;
      bif.wdata1 = pend[1].wdata;
      bif.PREADY1 = ($urandom_range(0, 3) != 0);
      bif.PREADY2 = ($urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
